// File: rtl/dcache_controller.sv
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and off-chip data memory. Hits finish in the requesting cycle. A miss
// raises cpu_stall_o until the line has been refilled. The memory side
// moves whole 256-bit lines using an enable/ack handshake.
//
// Ports
//   clk_i, rst_i      clock (rising edge), synchronous active-low reset
//   cpu_addr_i        byte address; [4:2] word, [9:5] index, [31:10] tag
//   cpu_wdata_i       store data
//   cpu_read_i        load request
//   cpu_write_i       store request (wins if both are set)
//   cpu_rdata_o       load data, combinational on a read hit, else 0
//   cpu_stall_o       freeze the pipeline while a miss is serviced
//   mem_addr_o        line-aligned memory address
//   mem_wdata_o       victim line for writeback
//   mem_enable_o      memory request valid
//   mem_write_o       1 = writeback, 0 = refill
//   mem_rdata_i       refill line
//   mem_ack_i         one-cycle completion pulse
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | serve hits, detect misses
// WRITEBACK  | write the dirty victim line to memory, wait for ack
// ALLOCATE   | fetch the requested line from memory, wait for ack
// REFILLED   | one settling cycle; the held request then hits in IDLE
module dcache_controller #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 5,
    parameter int LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int LINES  = 1 << INDEX_W;
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_REFILLED  = 2'd3
    } state_t;

    state_t state_q;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINE_W-1:0]  data_q [LINES];

    logic [TAG_W-1:0]   miss_tag_q;
    logic [INDEX_W-1:0] miss_idx_q;

    logic [WSEL_W-1:0]  word_sel;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req;
    logic               hit;
    logic [31:0]        hit_word;
    logic               unused_addr_bits;

    assign word_sel = cpu_addr_i[OFF_W-1:2];
    assign idx      = cpu_addr_i[OFF_W +: INDEX_W];
    assign req_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    // Word-only access: the byte offset is intentionally ignored.
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign req      = cpu_read_i | cpu_write_i;
    assign hit      = req & valid_q[idx] & (tag_q[idx] == req_tag);
    assign hit_word = data_q[idx][{word_sel, 5'b00000} +: 32];

    // Stall is combinational so a miss freezes the pipeline in the cycle
    // it is detected; every non-IDLE state stalls unconditionally.
    assign cpu_stall_o = (state_q != S_IDLE) || (req && !hit);

    // A simultaneous read and write counts as a write and returns no data.
    assign cpu_rdata_o = (state_q == S_IDLE && cpu_read_i && !cpu_write_i && hit)
                         ? hit_word : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (cpu_write_i) dirty_q[idx] <= 1'b1;
                        end else begin
                            // The miss address is captured here; later
                            // states use only the latched copy.
                            miss_tag_q   <= req_tag;
                            miss_idx_q   <= idx;
                            mem_enable_o <= 1'b1;
                            if (valid_q[idx] && dirty_q[idx]) begin
                                state_q     <= S_WRITEBACK;
                                mem_write_o <= 1'b1;
                                mem_addr_o  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
                                mem_wdata_o <= data_q[idx];
                            end else begin
                                state_q     <= S_ALLOCATE;
                                mem_write_o <= 1'b0;
                                mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
                            end
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= S_ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q              <= S_REFILLED;
                        mem_enable_o         <= 1'b0;
                        valid_q[miss_idx_q]  <= 1'b1;
                        dirty_q[miss_idx_q]  <= 1'b0;
                    end
                end
                S_REFILLED: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state_q == S_IDLE && hit && cpu_write_i) begin
                data_q[idx][{word_sel, 5'b00000} +: 32] <= cpu_wdata_i;
            end else if (state_q == S_ALLOCATE && mem_ack_i) begin
                data_q[miss_idx_q] <= mem_rdata_i;
                tag_q[miss_idx_q]  <= miss_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller. The reference model treats the cache as
// transparent memory (golden word map plus a backing line store) and tracks
// only which line each index holds and whether it is dirty, to predict
// hits, writebacks, refills and stall length.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic         cpu_read_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    dcache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_read_i   (cpu_read_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    // Program-visible memory and backing store
    logic [31:0]  golden    [logic [29:0]];
    logic [255:0] mem_lines [logic [26:0]];

    // Which line each index holds
    logic [31:0]  m_valid;
    logic [31:0]  m_dirty;
    logic [21:0]  m_tag [32];

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [255:0] mem_line(input logic [26:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word({la, 3'(i)});
        return l;
    endfunction

    function automatic logic [31:0] get_word(input logic [29:0] wa);
        logic [255:0] l;
        if (golden.exists(wa)) return golden[wa];
        l = mem_line(wa[29:3]);
        return l[{wa[2:0], 5'b00000} +: 32];
    endfunction

    function automatic logic [255:0] expect_line(input logic [26:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = get_word({la, 3'(i)});
        return l;
    endfunction

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        logic [255:0] l;
        l = mem_line(a[31:5]);
        l[{a[4:2], 5'b00000} +: 32] = v;
        mem_lines[a[31:5]] = l;
    endtask

    // One CPU access, with the bench acting as memory while the DUT stalls.
    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic rd, input logic wr);
        logic [4:0]  ix;
        logic [21:0] tg;
        logic        exp_hit, exp_wb, in_txn;
        logic [26:0] vla;
        int stalls, wbs, rfs, guard, wait_n, delay, exp_stalls;
        ix      = a[9:5];
        tg      = a[31:10];
        exp_hit = m_valid[ix] && (m_tag[ix] == tg);
        exp_wb  = !exp_hit && m_valid[ix] && m_dirty[ix];
        vla     = {m_tag[ix], ix};
        stalls = 0; wbs = 0; rfs = 0; guard = 0; wait_n = 0; delay = 0;
        exp_stalls = 0; in_txn = 1'b0;

        @(negedge clk_i);
        cpu_addr_i = a; cpu_wdata_i = wd; cpu_read_i = rd; cpu_write_i = wr;
        #1;
        while (cpu_stall_o && guard < 100) begin
            guard++;
            stalls++;
            if (mem_enable_o) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wait_n = 0;
                    delay  = $urandom_range(0, 3);
                    exp_stalls += delay + 1;
                    if (mem_write_o) begin
                        wbs++;
                        check("wb_addr", 256'(mem_addr_o), 256'({vla, 5'b00000}));
                        check("wb_data", mem_wdata_o, expect_line(vla));
                    end else begin
                        rfs++;
                        check("rf_addr", 256'(mem_addr_o), 256'({a[31:5], 5'b00000}));
                    end
                end
                if (wait_n == delay) begin
                    if (mem_write_o) mem_lines[mem_addr_o[31:5]] = mem_wdata_o;
                    else mem_rdata_i = mem_line(mem_addr_o[31:5]);
                    mem_ack_i = 1'b1;
                    in_txn = 1'b0;
                end else begin
                    wait_n++;
                end
            end
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            #1;
        end
        check("stall_bound", 256'(guard >= 100), 256'(0));
        if (!exp_hit) exp_stalls += 2;
        check("stall_cycles", 256'(stalls), 256'(exp_stalls));
        check("writebacks", 256'(wbs), 256'(exp_wb));
        check("refills", 256'(rfs), 256'(!exp_hit));
        check("enable_after", 256'(mem_enable_o), 256'(0));
        if (rd && !wr) check("rdata", 256'(cpu_rdata_o), 256'(get_word(a[31:2])));
        else           check("rdata_zero", 256'(cpu_rdata_o), 256'(0));

        if (wr) golden[a[31:2]] = wd;
        if (!exp_hit) m_dirty[ix] = 1'b0;
        if (wr) m_dirty[ix] = 1'b1;
        m_valid[ix] = 1'b1;
        m_tag[ix]   = tg;
    endtask

    task automatic idle_check();
        @(negedge clk_i);
        cpu_read_i = 1'b0; cpu_write_i = 1'b0;
        cpu_addr_i = $urandom;
        #1;
        check("idle_rdata", 256'(cpu_rdata_o), 256'(0));
        check("idle_stall", 256'(cpu_stall_o), 256'(0));
    endtask

    initial begin
        int guard;
        logic [31:0] a;
        int r;
        rst_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0; cpu_read_i = 1'b0; cpu_write_i = 1'b0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;
        m_valid = '0; m_dirty = '0;
        for (int i = 0; i < 32; i++) m_tag[i] = '0;
        preload(32'h0000_0400, 32'h1111_1111);

        repeat (3) @(negedge clk_i);
        #1;
        check("rst_enable", 256'(mem_enable_o), 256'(0));
        check("rst_write", 256'(mem_write_o), 256'(0));
        check("rst_stall", 256'(cpu_stall_o), 256'(0));
        check("rst_rdata", 256'(cpu_rdata_o), 256'(0));
        check("rst_addr", 256'(mem_addr_o), 256'(0));
        rst_i = 1'b1;

        // Directed sequence
        access(32'h0000_0400, 32'h0, 1'b1, 1'b0);          // cold miss, 0x11111111
        check("tp_word0", 256'(cpu_rdata_o), 256'(32'h1111_1111));
        access(32'h0000_0400, 32'h0, 1'b1, 1'b0);          // hit
        access(32'h0000_0404, 32'hDEAD_BEEF, 1'b0, 1'b1);  // write hit
        access(32'h0000_0404, 32'h0, 1'b1, 1'b0);          // reads back DEADBEEF
        check("tp_deadbeef", 256'(cpu_rdata_o), 256'(32'hDEAD_BEEF));
        access(32'h0000_0804, 32'h0, 1'b1, 1'b0);          // dirty conflict
        access(32'h0000_0C00, 32'h0, 1'b1, 1'b0);          // clean conflict
        access(32'h0000_1008, 32'h0000_0005, 1'b0, 1'b1);  // write miss
        access(32'h0000_1008, 32'h0, 1'b1, 1'b0);
        check("tp_merge", 256'(cpu_rdata_o), 256'(32'h5));
        access(32'h0000_1000, 32'h0, 1'b1, 1'b0);
        access(32'h0000_0408, 32'h0, 1'b1, 1'b0);          // evicts merged line
        access(32'h0000_0400, 32'h1234_5678, 1'b1, 1'b1);  // read+write = write
        idle_check();

        // Reset during ALLOCATE
        access(32'h0000_00A4, 32'h0, 1'b1, 1'b0);
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_20A4; cpu_read_i = 1'b1; cpu_write_i = 1'b0;
        #1;
        check("rm_miss_stall", 256'(cpu_stall_o), 256'(1));
        guard = 0;
        while (!(mem_enable_o && !mem_write_o) && guard < 10) begin
            @(negedge clk_i);
            #1;
            guard++;
        end
        check("rm_alloc_reached", 256'(mem_enable_o && !mem_write_o), 256'(1));
        @(negedge clk_i);
        rst_i = 1'b0; cpu_read_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rm_enable", 256'(mem_enable_o), 256'(0));
        check("rm_stall", 256'(cpu_stall_o), 256'(0));
        check("rm_write", 256'(mem_write_o), 256'(0));
        check("rm_addr", 256'(mem_addr_o), 256'(0));
        mem_rdata_i = {8{32'hBAD0_BAD0}};
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("late_ack_enable", 256'(mem_enable_o), 256'(0));
        check("late_ack_stall", 256'(cpu_stall_o), 256'(0));
        m_valid = '0; m_dirty = '0;
        golden.delete();
        access(32'h0000_00A4, 32'h0, 1'b1, 1'b0);          // must miss again
        access(32'h0000_20A4, 32'h0, 1'b1, 1'b0);

        // Randomized traffic over a few conflicting tags
        for (int n = 0; n < 150; n++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'b00};
            r = $urandom_range(0, 9);
            if (r < 5)      access(a, $urandom, 1'b1, 1'b0);
            else if (r < 9) access(a, $urandom, 1'b0, 1'b1);
            else            access(a, $urandom, 1'b1, 1'b1);
            if ((n % 25) == 0) idle_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
